// File: rtl/cordic_pkg.sv
// Shared widths, constants and dispatcher state encoding for the cordic front end.
package cordic_pkg;

  localparam int unsigned THETA_W  = 23;
  localparam int unsigned RESULT_W = 22;

  localparam logic [THETA_W-1:0] THETA_ONE = 23'h200000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } dispatch_state_t;

  // Returns {sat, theta}: cosine is even, so fold to |theta| and clamp above 1.0.
  function automatic logic [THETA_W:0] condition_theta(input logic [THETA_W-1:0] theta);
    logic [THETA_W-1:0] mag;
    mag = theta[THETA_W-1] ? (~theta + 1'b1) : theta;
    if (mag > THETA_ONE) begin
      return {1'b1, THETA_ONE};
    end
    return {1'b0, mag};
  endfunction

endpackage

// File: rtl/cordic_dispatch_fifo.sv
// Show-ahead synchronous request FIFO with a registered occupancy count.
module cordic_dispatch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clk_en_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthCnt = Depth[PtrW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == DepthCnt);
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_rd = clk_en_i && rd_en_i && !empty_o;
  // A write into a full FIFO is legal when the head leaves in the same cycle.
  assign do_wr = clk_en_i && wr_en_i && (!full_o || do_rd);

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cordic_dispatch.sv
// Stream front end for the cordic core: queue, condition, issue, collect the result.
// Define CORDIC_DISPATCH_TIMEOUT_EN to add the WAIT watchdog that drives out_err.
module cordic_dispatch
  import cordic_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                in_valid,
  input  logic [THETA_W-1:0]  in_theta,
  output logic                in_ready,
  output logic                cordic_clk_en,
  output logic                cordic_start,
  output logic [THETA_W-1:0]  cordic_theta,
  input  logic                cordic_done,
  input  logic [RESULT_W-1:0] cordic_result,
  output logic                out_valid,
  output logic [RESULT_W-1:0] out_result,
  output logic                out_sat,
  output logic                out_err,
  input  logic                out_ready
);

  dispatch_state_t state_q, state_d;

  logic [THETA_W:0]    enq_data, head_data;
  logic                fifo_full, fifo_empty, pop;
  logic [THETA_W-1:0]  theta_q;
  logic                issue_sat_q;
  logic                out_valid_q, out_sat_q;
  logic [RESULT_W-1:0] out_result_q;
  logic                timeout;

  assign enq_data = condition_theta(in_theta);
  assign in_ready = !fifo_full;
  assign pop      = (state_q == IDLE) && !fifo_empty && !out_valid_q;

  cordic_dispatch_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (THETA_W + 1)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clk_en_i  (clk_en),
    .wr_en_i   (in_valid && in_ready),
    .wr_data_i (enq_data),
    .rd_en_i   (pop),
    .rd_data_o (head_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cordic_done || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      theta_q     <= '0;
      issue_sat_q <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      if (pop) begin
        theta_q     <= head_data[THETA_W-1:0];
        issue_sat_q <= head_data[THETA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_sat_q    <= 1'b0;
    end else if (clk_en) begin
      if (state_q == WAIT && cordic_done) begin
        out_valid_q  <= 1'b1;
        out_result_q <= cordic_result;
        out_sat_q    <= issue_sat_q;
      end else if (timeout) begin
        out_valid_q  <= 1'b1;
        out_result_q <= '0;
        out_sat_q    <= 1'b0;
      end else if (out_valid_q && out_ready) begin
        out_valid_q  <= 1'b0;
        out_result_q <= '0;
        out_sat_q    <= 1'b0;
      end
    end
  end

`ifdef CORDIC_DISPATCH_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] wait_cnt_q;
  logic            out_err_q;

  // A done landing on the last watchdog cycle still wins.
  assign timeout = (state_q == WAIT) && !cordic_done && (wait_cnt_q == CntLast);
  assign out_err = out_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      out_err_q  <= 1'b0;
    end else if (clk_en) begin
      if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
      else                 wait_cnt_q <= '0;
      if (state_q == WAIT && cordic_done) out_err_q <= 1'b0;
      else if (timeout)                   out_err_q <= 1'b1;
      else if (out_valid_q && out_ready)  out_err_q <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign out_err = 1'b0;
`endif

  assign cordic_clk_en = clk_en;
  assign cordic_start  = clk_en && (state_q == ISSUE);
  assign cordic_theta  = theta_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_sat       = out_sat_q;

endmodule

// File: tb/tb_cordic_dispatch.sv
// Directed bench for cordic_dispatch with a fixed-latency core stand-in and a queue model.
module tb_cordic_dispatch;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset, clk_en, in_valid, in_ready, cordic_clk_en, cordic_start, cordic_done;
  logic [22:0] in_theta, cordic_theta;
  logic [21:0] cordic_result, out_result;
  logic        out_valid, out_sat, out_err, out_ready;
  logic        spur_done, never_done;

  always #5 clk = ~clk;

  cordic_dispatch #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .in_valid      (in_valid),
    .in_theta      (in_theta),
    .in_ready      (in_ready),
    .cordic_clk_en (cordic_clk_en),
    .cordic_start  (cordic_start),
    .cordic_theta  (cordic_theta),
    .cordic_done   (cordic_done),
    .cordic_result (cordic_result),
    .out_valid     (out_valid),
    .out_result    (out_result),
    .out_sat       (out_sat),
    .out_err       (out_err),
    .out_ready     (out_ready)
  );

  // Stand-in core: result is a simple function of theta, done L enabled cycles after start.
  function automatic logic [21:0] core_fn(input logic [22:0] th);
    return th[21:0] + 22'h001234;
  endfunction

  logic        core_busy, model_done;
  int          core_cnt;
  logic [22:0] core_th;
  logic [21:0] model_res;

  assign cordic_done   = model_done | spur_done;
  assign cordic_result = model_res;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_busy  <= 1'b0;
      core_cnt   <= 0;
      core_th    <= '0;
      model_done <= 1'b0;
      model_res  <= '0;
    end else if (clk_en) begin
      model_done <= 1'b0;
      if (cordic_start) begin
        core_busy <= !never_done;
        core_cnt  <= L - 1;
        core_th   <= cordic_theta;
      end else if (core_busy) begin
        if (core_cnt == 1) begin
          core_busy  <= 1'b0;
          model_done <= 1'b1;
          model_res  <= core_fn(core_th);
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  typedef struct packed {
    logic [22:0] th;
    logic [21:0] res;
    logic        sat;
    logic        err;
  } exp_t;

  exp_t        ex_q[$];
  logic [22:0] th_q[$];
  exp_t        mon_e;

  int vectors = 0, miscompares = 0;
  int cyc = 0, acc_cyc = 0, starts = 0, outs = 0, last_start_cyc = 0;
  logic [22:0] last_start_theta = '0;
  logic        prev_valid = 1'b0;

  // Fold to magnitude, clamp anything above 1.0 (2^21) and flag it.
  function automatic exp_t model(input logic [22:0] raw, input logic to_mode);
    exp_t e;
    int   v, mag;
    v   = int'($signed(raw));
    mag = (v < 0) ? -v : v;
    if (mag > 2097152) begin
      e.th  = 23'h200000;
      e.sat = 1'b1;
    end else begin
      e.th  = mag[22:0];
      e.sat = 1'b0;
    end
    e.res = to_mode ? 22'h0 : core_fn(e.th);
    e.err = to_mode;
    if (to_mode) e.sat = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      th_q.delete();
      ex_q.delete();
      prev_valid = 1'b0;
    end else begin
      check("clk_en_fwd", 32'(cordic_clk_en), 32'(clk_en));
      if (cordic_start) begin
        starts++;
        last_start_cyc   = cyc;
        last_start_theta = cordic_theta;
        if (th_q.size() == 0) check("start_expected", 32'(cordic_start), 32'd0);
        else                  check("cordic_theta", 32'(cordic_theta), 32'(th_q.pop_front()));
      end
      if (out_valid) begin
        if (!prev_valid) outs++;
        if (ex_q.size() == 0) begin
          check("out_expected", 32'(out_valid), 32'd0);
        end else begin
          mon_e = ex_q[0];
          check("out_result", 32'(out_result), 32'(mon_e.res));
          check("out_sat", 32'(out_sat), 32'(mon_e.sat));
          check("out_err", 32'(out_err), 32'(mon_e.err));
          if (out_ready && clk_en) void'(ex_q.pop_front());
        end
      end
      prev_valid = out_valid && !(out_ready && clk_en);
      if (in_valid && in_ready && clk_en) begin
        mon_e = model(in_theta, never_done);
        ex_q.push_back(mon_e);
        th_q.push_back(mon_e.th);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [22:0] th);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_theta = th;
    forever begin
      @(negedge clk);
      if (in_ready && clk_en && reset) break;
      n++;
      if (n > 200) begin
        check("push_accept", 32'(in_ready), 32'd1);
        break;
      end
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_arrives", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (!cordic_start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("start_arrives", 32'(cordic_start), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_start"}, 32'(cordic_start), 32'd0);
    check({tag, "_theta"}, 32'(cordic_theta), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_result"}, 32'(out_result), 32'd0);
    check({tag, "_out_sat"}, 32'(out_sat), 32'd0);
    check({tag, "_out_err"}, 32'(out_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected $finish");
    $fatal(1);
  end

  initial begin
    int s, o, sc, n;
    reset = 1'b0; clk_en = 1'b1; in_valid = 1'b0; in_theta = '0;
    out_ready = 1'b1; spur_done = 1'b0; never_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    step(2);

    // Single request: latency accept->start 2, accept->out_valid L+3.
    push(23'h200000);
    wait_out(50);
    check("t1_latency", 32'(cyc - acc_cyc), 32'd7);
    check("t1_start_cyc", 32'(last_start_cyc - acc_cyc), 32'd2);
    check("t1_theta", 32'(last_start_theta), 32'h200000);
    check("t1_result", 32'(out_result), 32'h201234);
    check("t1_sat", 32'(out_sat), 32'd0);
    step(1);

    push(23'h600000);
    wait_out(50);
    check("neg1_theta", 32'(last_start_theta), 32'h200000);
    check("neg1_sat", 32'(out_sat), 32'd0);
    step(1);
    push(23'h300000);
    wait_out(50);
    check("p15_theta", 32'(last_start_theta), 32'h200000);
    check("p15_sat", 32'(out_sat), 32'd1);
    step(1);
    push(23'h400000);
    wait_out(50);
    check("minneg_sat", 32'(out_sat), 32'd1);
    step(1);
    push(23'h7FF000);
    wait_out(50);
    check("smallneg_theta", 32'(last_start_theta), 32'h001000);
    check("smallneg_result", 32'(out_result), 32'h002234);
    step(1);

    // Back-pressure: one result held, four queued, FIFO full.
    out_ready = 1'b0;
    s = starts;
    push(23'h010000); push(23'h7F0000); push(23'h020000); push(23'h250000); push(23'h030000);
    step(10);
    check("bp_starts", 32'(starts - s), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    n = 0;
    while (ex_q.size() != 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("bp_drained", 32'(ex_q.size()), 32'd0);
    check("bp_all_started", 32'(starts - s), 32'd5);
    step(2);

    // clk_en low for three WAIT cycles stretches latency by three.
    s = starts;
    push(23'h0ABCDE);
    wait_start(20);
    @(posedge clk); #1;
    clk_en = 1'b0;
    step(3);
    clk_en = 1'b1;
    wait_out(50);
    check("ce_latency", 32'(cyc - acc_cyc), 32'd10);
    check("ce_result", 32'(out_result), 32'h0ACF12);
    #1;
    check("ce_starts", 32'(starts - s), 32'd1);
    step(2);

    // A done pulse outside WAIT must not produce a result.
    o = outs;
    spur_done = 1'b1;
    step(1);
    spur_done = 1'b0;
    step(5);
    check("spur_outs", 32'(outs - o), 32'd0);
    check("spur_out_valid", 32'(out_valid), 32'd0);

`ifdef CORDIC_DISPATCH_TIMEOUT_EN
    never_done = 1'b1;
    push(23'h100000);
    wait_start(20);
    sc = cyc;
    wait_out(200);
    check("to_cycles", 32'(cyc - sc), 32'd65);
    check("to_err", 32'(out_err), 32'd1);
    check("to_result", 32'(out_result), 32'd0);
    step(1);
    never_done = 1'b0;
    push(23'h080000);
    wait_out(50);
    check("after_to_err", 32'(out_err), 32'd0);
    check("after_to_result", 32'(out_result), 32'h081234);
    step(1);
`else
    sc = 0;
`endif

    // Reset mid-WAIT with two requests queued behind the active one.
    s = starts;
    o = outs;
    push(23'h040000); push(23'h050000); push(23'h060000);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    @(posedge clk); #1;
    reset = 1'b1;
    step(30);
    check("midrst_outs", 32'(outs - o), 32'd0);
    check("midrst_starts", 32'(starts - s), 32'd1);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
